// File: rtl/nand_gate_sequencer.sv
// nand_gate_sequencer: computes a selected basic gate as a sequence of steps
// through one shared external NAND cell, one step per clock.
module nand_gate_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] nand_in1,
   output logic [WIDTH-1:0] nand_in2,
   input  logic [WIDTH-1:0] nand_out,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             err
);
   typedef enum logic {IDLE, EXEC} state_t;
   state_t state;
   logic [2:0] op_r, step, last;
   logic [WIDTH-1:0] a, b, t1, t2, t3;

   assign last = (op_r == 3'd6) ? 3'd5 :
                 (op_r == 3'd4 || op_r == 3'd5) ? 3'd4 :
                 (op_r == 3'd3) ? 3'd3 :
                 (op_r == 3'd2) ? 3'd2 : 3'd1;

   always_comb begin
      nand_in1 = '0;
      nand_in2 = '0;
      if (state == EXEC)
         case (op_r)
            3'd0: begin nand_in1 = a; nand_in2 = b; end
            3'd1: begin nand_in1 = a; nand_in2 = a; end
            3'd2: begin
               nand_in1 = (step == 3'd1) ? a : t1;
               nand_in2 = (step == 3'd1) ? b : t1;
            end
            3'd3, 3'd4:
               case (step)
                  3'd1: begin nand_in1 = a; nand_in2 = a; end
                  3'd2: begin nand_in1 = b; nand_in2 = b; end
                  3'd3: begin nand_in1 = t1; nand_in2 = t2; end
                  default: begin nand_in1 = t3; nand_in2 = t3; end
               endcase
            3'd5, 3'd6:
               case (step)
                  3'd1: begin nand_in1 = a; nand_in2 = b; end
                  3'd2: begin nand_in1 = a; nand_in2 = t1; end
                  3'd3: begin nand_in1 = b; nand_in2 = t1; end
                  3'd4: begin nand_in1 = t2; nand_in2 = t3; end
                  default: begin nand_in1 = t1; nand_in2 = t1; end
               endcase
            default: ;
         endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         out   <= '0;
         step  <= '0;
         op_r  <= '0;
         a     <= '0;
         b     <= '0;
         t1    <= '0;
         t2    <= '0;
         t3    <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  a     <= in1;
                  b     <= in2;
                  op_r  <= op;
                  step  <= 3'd1;
                  busy  <= 1'b1;
                  state <= EXEC;
               end
            default:
               if (step == last) begin
                  out   <= (op_r == 3'd7) ? '0 : nand_out;
                  err   <= (op_r == 3'd7);
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  step  <= '0;
                  state <= IDLE;
               end else begin
                  // step 4 only occurs for XNOR, whose fourth result goes back into t1
                  case (step)
                     3'd1: t1 <= nand_out;
                     3'd2: t2 <= nand_out;
                     3'd3: t3 <= nand_out;
                     default: t1 <= nand_out;
                  endcase
                  step <= step + 3'd1;
               end
         endcase
      end
   end
endmodule
